// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Bundles the three request/memory/response channels of the load/store unit.
//   Parameters: ADDRESS_WIDTH (byte address width of the RAM port),
//               DATA_WIDTH (word width, 32).
//   Core side : req_valid/req_ready handshake, req_we, req_funct3, req_addr, req_wdata.
//   RAM side  : mem_addr, mem_be, mem_wdata, mem_we out; mem_rdata back (one-cycle RAM).
//   Response  : rsp_valid pulse with rsp_rdata and rsp_err.
//   Modports  : slave  = the load/store unit
//               master = the environment (core plus RAM)
interface load_store_unit_if #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [31:0]              req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;

  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [3:0]               mem_be;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_we;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  logic                     rsp_valid;
  logic [DATA_WIDTH-1:0]    rsp_rdata;
  logic                     rsp_err;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready,
    output mem_addr, mem_be, mem_wdata, mem_we,
    input  mem_rdata,
    output rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  mem_addr, mem_be, mem_wdata, mem_we,
    output mem_rdata,
    input  rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-outstanding RISC-V style load/store unit in front of a RAM with a
//   registered (one-cycle) read port. Four-state FSM IDLE -> ISSUE ->
//   (CAPTURE for loads) -> RESP -> IDLE; req_ready is high only in IDLE.
//   Ports:
//     clk    - rising-edge clock
//     reset  - synchronous, active-high; abandons any in-flight access
//     bus    - load_store_unit_if.slave (request, RAM and response channels)
//   Latency from the acceptance edge: store response after edge 2, load
//   response after edge 3, trapped misaligned access after edge 1.
//   Build option: define LSU_MISALIGN_TRAP_EN to answer misaligned H/W
//   accesses with rsp_err=1 and no memory cycle; otherwise the low address
//   bits are forced to alignment and rsp_err is tied 0.
module load_store_unit #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32
) (
  input  logic            clk,
  input  logic            reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t                   state;

  // Request fields held for the lifetime of one access (data, no reset).
  logic                     we_q;
  logic [2:0]               funct3_q;
  logic [1:0]               off_q;

  // Registered outputs.
  logic [ADDRESS_WIDTH-1:0] mem_addr_r;
  logic [3:0]               mem_be_r;
  logic [DATA_WIDTH-1:0]    mem_wdata_r;
  logic                     mem_we_r;
  logic                     rsp_valid_r;
  logic [DATA_WIDTH-1:0]    rsp_rdata_r;

  // Address bits above the RAM window are deliberately dropped (wrap-around).
  logic                     unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:ADDRESS_WIDTH];

  // funct3[1:0]: 00 byte, 01 halfword, anything else word (covers 011/110/111).
  // funct3[2] selects zero-extension for the sub-word sizes.
  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return off;
      2'b01:   return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating across every lane lets the byte enables alone pick the target.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3[1:0])
      2'b00: begin
        if (f3[2]) ext = {24'd0, b};
        else       ext = b;
      end
      2'b01: begin
        if (f3[2]) ext = {16'd0, h};
        else       ext = h;
      end
      default: ext = rd;
    endcase
    return ext;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  logic rsp_err_r;
  logic trap_now;
  assign trap_now = misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
  logic trap_now;
  assign trap_now = 1'b0;
`endif

  // Request capture (data only).
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      we_q     <= bus.req_we;
      funct3_q <= bus.req_funct3;
      off_q    <= align_off(bus.req_funct3, bus.req_addr[1:0]);
    end
  end

  // FSM and registered outputs. rsp_valid follows the RESP state by one edge,
  // which sets the store/load/trap latencies to 2/3/1 edges after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_addr_r  <= '0;
      mem_be_r    <= '0;
      mem_wdata_r <= '0;
      mem_we_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      rsp_err_r   <= 1'b0;
`endif
    end else begin
      rsp_valid_r <= (state == RESP);
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            rsp_rdata_r <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            rsp_err_r   <= trap_now;
`endif
            if (trap_now) begin
              state <= RESP;
            end else begin
              mem_addr_r  <= {bus.req_addr[ADDRESS_WIDTH-1:2], 2'b00};
              mem_be_r    <= lane_en(bus.req_funct3,
                                     align_off(bus.req_funct3, bus.req_addr[1:0]));
              mem_wdata_r <= store_lanes(bus.req_funct3, bus.req_wdata);
              mem_we_r    <= bus.req_we;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // The write strobe was seen by the RAM on this edge; drop it now.
          mem_we_r <= 1'b0;
          mem_be_r <= 4'b0000;
          state    <= we_q ? RESP : CAPTURE;
        end
        CAPTURE: begin
          rsp_rdata_r <= load_fmt(funct3_q, off_q, bus.mem_rdata);
          state       <= RESP;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_be    = mem_be_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.rsp_err   = rsp_err_r;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDRESS_WIDTH, default 10, byte-address width of the memory port.
REQ-002 Parameter: DATA_WIDTH, default 32, word width; only 32 is supported, as four 8-bit byte lanes.
REQ-003 Port: clk  input  1  single clock; every register updates on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req_valid  input  1  core presents a memory request.
REQ-006 Port: req_ready  output  1  unit accepts a request this cycle.
REQ-007 Port: req_we  input  1  1 = store, 0 = load.
REQ-008 Port: req_funct3  input  3  RISC-V size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 Port: req_addr  input  32  byte address.
REQ-010 Port: req_wdata  input  32  store data, right-aligned.
REQ-011 Port: mem_addr  output  ADDRESS_WIDTH  byte address to the RAM; bits [1:0] are always 0.
REQ-012 Port: mem_be  output  4  byte-lane enables.
REQ-013 Port: mem_wdata  output  32  lane-positioned store data.
REQ-014 Port: mem_we  output  1  write strobe.
REQ-015 Port: mem_rdata  input  32  RAM read data, registered inside the RAM, valid one cycle after mem_addr.
REQ-016 Port: rsp_valid  output  1  one-cycle response pulse.
REQ-017 Port: rsp_rdata  output  32  formatted load data; 0 for stores.
REQ-018 Port: rsp_err  output  1  misaligned access; qualified by rsp_valid.

Function
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, CAPTURE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 In IDLE, when req_valid=1, the unit SHALL register the request and go to ISSUE.
REQ-021 In ISSUE, the unit SHALL drive mem_addr = {addr[ADDRESS_WIDTH-1:2],2'b00}, mem_be and mem_wdata; mem_we SHALL be 1 only for stores.
REQ-022 From ISSUE, a store SHALL go to RESP and a load SHALL go to CAPTURE.
REQ-023 Outside ISSUE, mem_we SHALL be 0 and mem_be SHALL be 0.
REQ-024 In CAPTURE, the unit SHALL latch formatted mem_rdata into rsp_rdata and go to RESP.
REQ-025 In RESP, rsp_valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; there is no backpressure.
REQ-026 Latency SHALL be fixed. Counting the acceptance edge as edge 0, rsp_valid is high after edge 2 for stores and after edge 3 for loads.
REQ-027 Byte enables SHALL be: B → 4'b0001<<addr[1:0]; H → 4'b0011<<addr[1:0]; W → 4'b1111.
REQ-028 Store data SHALL be replicated across lanes: B → {4{wdata[7:0]}}; H → {2{wdata[15:0]}}; W → wdata.
REQ-029 Load data SHALL be formatted as follows: the selected lane/halfword is chosen by addr[1:0]; B/H are sign-extended to 32 bits; BU/HU are zero-extended.
REQ-030 Unused funct3 codes (011, 110, 111) SHALL be treated as W.
REQ-031 Request inputs outside IDLE SHALL be ignored; no request is queued.
REQ-032 Address bits above ADDRESS_WIDTH-1 SHALL be ignored, so addresses wrap modulo 2^ADDRESS_WIDTH.

Reset
REQ-033 While reset=1, the FSM SHALL be forced to IDLE on the next edge, including mid-transaction, and any in-flight access SHALL be abandoned without a response.
REQ-034 Reset values SHALL be: req_ready=1 (IDLE), mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-035 A reset asserted during ISSUE SHALL still allow that cycle's mem_we to have been seen by the RAM; this write is not suppressed retroactively.

Configuration
REQ-036 Macro LSU_MISALIGN_TRAP_EN SHALL select the misaligned-access behaviour.
- Defined: H with addr[0]=1, or W with addr[1:0]≠0, SHALL go IDLE→RESP directly with rsp_err=1 and rsp_rdata=0. No memory cycle occurs (mem_we stays 0) and the response arrives after edge 1.
- Undefined: the low address bits are forced to alignment (H clears addr[0], W clears addr[1:0]), the access proceeds normally, and rsp_err is tied 0.

Verification
REQ-037 SW addr=0x10, wdata=0xDEADBEEF → ISSUE shows mem_addr=0x10, mem_be=1111, mem_we=1; rsp_valid 2 cycles after acceptance with rsp_err=0.
REQ-038 With RAM word 0x10=0x8001FF7F:
- LB addr=0x12 → rsp_rdata=0x00000001.
- LB addr=0x11 → rsp_rdata=0xFFFFFFFF.
- LHU addr=0x12 → rsp_rdata=0x00008001.
- LH addr=0x12 → rsp_rdata=0xFFFF8001.
Each response arrives 3 cycles after acceptance.
REQ-039 SB addr=0x13, wdata=0x000000AB → mem_be=1000, mem_wdata=0xABABABAB; a subsequent LW addr=0x10 returns 0xAB01FF7F.
REQ-040 LW addr=0x12 → with LSU_MISALIGN_TRAP_EN: rsp_err=1 after edge 1 and mem_we never asserted; without: mem_addr=0x10 and normal data returned.
REQ-041 Assert reset in CAPTURE → no rsp_valid; req_ready=1 the cycle after reset deasserts; a following SW completes normally.
REQ-042 Hold req_valid=1 through an entire load → exactly one response; a second request is accepted only after RESP.
